reg_writeback_ctrl: RTL and testbench

//  Write-side master of the 32x32 register file. Merges ALU results and out-of-order-latency

---
 rtl/mips_pkg.sv | 17 +
 rtl/wb_addr_fifo.sv | 67 ++++++
 rtl/reg_writeback_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, the hard-wired zero register and write-port source encoding
// for the register-file write-back path.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_NONE    = 2'd0,
        WB_LOAD    = 2'd1,
        WB_ALU_BUF = 2'd2,
        WB_ALU     = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_addr_fifo.sv
// Queue of destination registers for outstanding loads. Every slot is exposed with
// its valid bit so that the hazard compare can see the whole queue.
module wb_addr_fifo #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [ADDR_W-1:0]             push_addr_i,
    input  logic                          pop_i,
    output logic [ADDR_W-1:0]             head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entries_o,
    output logic [DEPTH-1:0]              valid_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
    logic                         do_push, do_pop;

    // A ring buffer: the slot under the write pointer is occupied only when full,
    // the slot under the read pointer is free only when empty.
    assign full_o    = valid_q[wr_ptr_q];
    assign empty_o   = !valid_q[rd_ptr_q];
    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        mem_d    = mem_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_addr_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port master: arbitrates load returns and ALU results, tracks
// pending load destinations for hazards. Define FORWARD_EN for write-to-read bypass outputs.
module reg_writeback_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    input  logic              ldIssue,
    input  logic [ADDR_W-1:0] ldIssueAddr,
    output logic              ldIssueReady,
    input  logic              ldRspValid,
    input  logic [DATA_W-1:0] ldRspData,
    input  logic [ADDR_W-1:0] readAddress1,
    input  logic [ADDR_W-1:0] readAddress2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    output logic              protoErr
`ifdef FORWARD_EN
    ,
    output logic              fwdValid1,
    output logic [DATA_W-1:0] fwdData1,
    output logic              fwdValid2,
    output logic [DATA_W-1:0] fwdData2
`endif
);

    import mips_pkg::*;

    wb_src_e                        sel;
    logic [ADDR_W-1:0]              sel_addr;
    logic [DATA_W-1:0]              sel_data;

    logic                           buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]              buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]              buf_data_q, buf_data_d;

    logic                           we_q, we_d;
    logic [ADDR_W-1:0]              wa_q, wa_d;
    logic [DATA_W-1:0]              wd_q, wd_d;
    logic                           perr_q, perr_d;

    logic                           lq_full, lq_empty, lq_push, ld_pop, alu_acc;
    logic [ADDR_W-1:0]              lq_head;
    logic [LQ_DEPTH-1:0][ADDR_W-1:0] lq_entries;
    logic [LQ_DEPTH-1:0]            lq_valid;

    assign aluReady     = !rst && !buf_valid_q;
    assign ldIssueReady = !rst && !lq_full;
    assign lq_push      = ldIssue && ldIssueReady;
    assign ld_pop       = ldRspValid && !lq_empty;
    assign alu_acc      = aluValid && aluReady;

    wb_addr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lq_push),
        .push_addr_i (ldIssueAddr),
        .pop_i       (ld_pop),
        .head_o      (lq_head),
        .full_o      (lq_full),
        .empty_o     (lq_empty),
        .entries_o   (lq_entries),
        .valid_o     (lq_valid)
    );

    always_comb begin
        sel      = WB_NONE;
        sel_addr = '0;
        sel_data = '0;
        if (ld_pop) begin
            sel      = WB_LOAD;
            sel_addr = lq_head;
            sel_data = ldRspData;
        end else if (buf_valid_q) begin
            sel      = WB_ALU_BUF;
            sel_addr = buf_addr_q;
            sel_data = buf_data_q;
        end else if (alu_acc) begin
            sel      = WB_ALU;
            sel_addr = aluAddr;
            sel_data = aluData;
        end

        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (sel == WB_ALU_BUF) begin
            buf_valid_d = 1'b0;
        end
        // aluReady is low while the buffer holds data, so a capture never overwrites it.
        if (alu_acc && sel != WB_ALU) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = aluAddr;
            buf_data_d  = aluData;
        end

        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (sel != WB_NONE && sel_addr != REG_ZERO) begin
            we_d = 1'b1;
            wa_d = sel_addr;
            wd_d = sel_data;
        end

        perr_d = perr_q || (ldRspValid && lq_empty);
    end

    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_valid[i] && lq_entries[i] == readAddress1 && readAddress1 != REG_ZERO)
                hazard1 = 1'b1;
            if (lq_valid[i] && lq_entries[i] == readAddress2 && readAddress2 != REG_ZERO)
                hazard2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            perr_q      <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            perr_q      <= perr_d;
        end
    end

    assign writeEn      = we_q;
    assign writeAddress = wa_q;
    assign writeData    = wd_q;
    assign protoErr     = perr_q;

`ifdef FORWARD_EN
    assign fwdValid1 = we_q && (wa_q == readAddress1);
    assign fwdValid2 = we_q && (wa_q == readAddress2);
    assign fwdData1  = fwdValid1 ? wd_q : '0;
    assign fwdData2  = fwdValid2 ? wd_q : '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl; forward outputs are checked when FORWARD_EN is defined.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid, aluReady;
    logic [4:0]  aluAddr;
    logic [31:0] aluData;
    logic        ldIssue, ldIssueReady;
    logic [4:0]  ldIssueAddr;
    logic        ldRspValid;
    logic [31:0] ldRspData;
    logic [4:0]  readAddress1, readAddress2;
    logic        hazard1, hazard2;
    logic        writeEn;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        protoErr;
`ifdef FORWARD_EN
    logic        fwdValid1, fwdValid2;
    logic [31:0] fwdData1, fwdData2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_writeback_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .aluValid     (aluValid),
        .aluReady     (aluReady),
        .aluAddr      (aluAddr),
        .aluData      (aluData),
        .ldIssue      (ldIssue),
        .ldIssueAddr  (ldIssueAddr),
        .ldIssueReady (ldIssueReady),
        .ldRspValid   (ldRspValid),
        .ldRspData    (ldRspData),
        .readAddress1 (readAddress1),
        .readAddress2 (readAddress2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .writeEn      (writeEn),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .protoErr     (protoErr)
`ifdef FORWARD_EN
        ,
        .fwdValid1    (fwdValid1),
        .fwdData1     (fwdData1),
        .fwdValid2    (fwdValid2),
        .fwdData2     (fwdData2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".writeEn"}, {63'd0, writeEn}, {63'd0, en});
        check({tag, ".writeAddress"}, {59'd0, writeAddress}, {59'd0, a});
        check({tag, ".writeData"}, {32'd0, writeData}, {32'd0, d});
    endtask

    initial begin
        rst = 1'b1;
        aluValid = 1'b0; aluAddr = '0; aluData = '0;
        ldIssue = 1'b0; ldIssueAddr = '0;
        ldRspValid = 1'b0; ldRspData = '0;
        readAddress1 = '0; readAddress2 = '0;

        // reset state
        tick(); tick();
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst.aluReady", {63'd0, aluReady}, 64'd0);
        check("rst.ldIssueReady", {63'd0, ldIssueReady}, 64'd0);
        check("rst.protoErr", {63'd0, protoErr}, 64'd0);
        check("rst.hazard1", {63'd0, hazard1}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst.aluReady", {63'd0, aluReady}, 64'd1);
        check("post_rst.ldIssueReady", {63'd0, ldIssueReady}, 64'd1);

        // ALU only
        aluValid = 1'b1; aluAddr = 5'd8; aluData = 32'h1234;
        tick();
        aluValid = 1'b0;
        check_wr("alu", 1'b1, 5'd8, 32'h1234);
        tick();
        check_wr("alu_idle", 1'b0, 5'd8, 32'h1234);

        // load response collides with ALU result
        ldIssue = 1'b1; ldIssueAddr = 5'd3;
        tick();
        ldIssue = 1'b0;
        readAddress1 = 5'd3;
        #1;
        check("col.hazard_pending", {63'd0, hazard1}, 64'd1);
        ldRspValid = 1'b1; ldRspData = 32'hAA;
        aluValid = 1'b1; aluAddr = 5'd9; aluData = 32'h55;
        #1;
        check("col.hazard_popping", {63'd0, hazard1}, 64'd1);
        check("col.aluReady_before", {63'd0, aluReady}, 64'd1);
        tick();
        ldRspValid = 1'b0; aluValid = 1'b0;
        #1;
        check_wr("col.load", 1'b1, 5'd3, 32'hAA);
        check("col.aluReady_buf", {63'd0, aluReady}, 64'd0);
        check("col.hazard_cleared", {63'd0, hazard1}, 64'd0);
        tick();
        check_wr("col.buf", 1'b1, 5'd9, 32'h55);
        check("col.aluReady_after", {63'd0, aluReady}, 64'd1);
        tick();
        check("col.idle", {63'd0, writeEn}, 64'd0);

        // hazards with loads to r5, r7, r0
        ldIssue = 1'b1; ldIssueAddr = 5'd5; tick();
        ldIssueAddr = 5'd7; tick();
        ldIssueAddr = 5'd0; tick();
        ldIssue = 1'b0;
        readAddress1 = 5'd7; readAddress2 = 5'd0;
        #1;
        check("haz.r7", {63'd0, hazard1}, 64'd1);
        check("haz.r0", {63'd0, hazard2}, 64'd0);
        readAddress2 = 5'd5;
        #1;
        check("haz.r5", {63'd0, hazard2}, 64'd1);
        ldRspValid = 1'b1; ldRspData = 32'h11;
        tick();
        check_wr("haz.rsp1", 1'b1, 5'd5, 32'h11);
        check("haz.r5_gone", {63'd0, hazard2}, 64'd0);
        check("haz.r7_still", {63'd0, hazard1}, 64'd1);
        ldRspData = 32'h22;
        tick();
        check_wr("haz.rsp2", 1'b1, 5'd7, 32'h22);
        check("haz.r7_gone", {63'd0, hazard1}, 64'd0);
        ldRspData = 32'h33;
        tick();
        ldRspValid = 1'b0;
        check_wr("haz.rsp_r0", 1'b0, 5'd7, 32'h22);
        check("haz.no_err", {63'd0, protoErr}, 64'd0);

        // queue full
        readAddress1 = '0; readAddress2 = '0;
        ldIssue = 1'b1;
        ldIssueAddr = 5'd1; tick();
        ldIssueAddr = 5'd2; tick();
        ldIssueAddr = 5'd3; tick();
        check("full.ready_at3", {63'd0, ldIssueReady}, 64'd1);
        ldIssueAddr = 5'd4; tick();
        check("full.ready_at4", {63'd0, ldIssueReady}, 64'd0);
        ldIssueAddr = 5'd6; tick();
        ldIssue = 1'b0;
        ldRspValid = 1'b1; ldRspData = 32'h44;
        tick();
        check("full.ready_after_pop", {63'd0, ldIssueReady}, 64'd1);
        check_wr("full.rsp1", 1'b1, 5'd1, 32'h44);
        ldRspData = 32'h45; tick();
        ldRspData = 32'h46; tick();
        check_wr("full.rsp3", 1'b1, 5'd3, 32'h46);
        ldRspData = 32'h47; tick();
        check_wr("full.rsp4", 1'b1, 5'd4, 32'h47);

        // response with empty queue (the push of r6 was dropped while full)
        ldRspData = 32'h99;
        tick();
        ldRspValid = 1'b0;
        check("err.protoErr", {63'd0, protoErr}, 64'd1);
        check_wr("err.no_write", 1'b0, 5'd4, 32'h47);
        tick();
        check("err.sticky", {63'd0, protoErr}, 64'd1);

        // reset mid-operation
        ldIssue = 1'b1; ldIssueAddr = 5'd10; tick();
        ldIssue = 1'b0;
        aluValid = 1'b1; aluAddr = 5'd11; aluData = 32'h77;
        rst = 1'b1;
        tick();
        aluValid = 1'b0;
        readAddress1 = 5'd10;
        #1;
        check_wr("mid_rst", 1'b0, 5'd0, 32'h0);
        check("mid_rst.protoErr", {63'd0, protoErr}, 64'd0);
        check("mid_rst.aluReady", {63'd0, aluReady}, 64'd0);
        check("mid_rst.hazard1", {63'd0, hazard1}, 64'd0);
        rst = 1'b0;
        tick();
        check("mid_rst.no_late_write", {63'd0, writeEn}, 64'd0);
        ldRspValid = 1'b1; ldRspData = 32'h5A;
        tick();
        ldRspValid = 1'b0;
        check("late_rsp.protoErr", {63'd0, protoErr}, 64'd1);
        check("late_rsp.no_write", {63'd0, writeEn}, 64'd0);

        // response in the same cycle as the first push is dropped; the entry still queues
        rst = 1'b1; tick(); rst = 1'b0;
        readAddress1 = 5'd12;
        ldIssue = 1'b1; ldIssueAddr = 5'd12;
        ldRspValid = 1'b1; ldRspData = 32'hC3;
        tick();
        ldIssue = 1'b0; ldRspValid = 1'b0;
        #1;
        check("same_cyc.protoErr", {63'd0, protoErr}, 64'd1);
        check("same_cyc.no_write", {63'd0, writeEn}, 64'd0);
        check("same_cyc.hazard1", {63'd0, hazard1}, 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        readAddress1 = '0;

`ifdef FORWARD_EN
        aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'hBEEF;
        tick();
        aluValid = 1'b0;
        readAddress1 = 5'd4; readAddress2 = 5'd5;
        #1;
        check("fwd.valid1", {63'd0, fwdValid1}, 64'd1);
        check("fwd.data1", {32'd0, fwdData1}, {32'd0, 32'hBEEF});
        check("fwd.valid2", {63'd0, fwdValid2}, 64'd0);
        check("fwd.data2", {32'd0, fwdData2}, 64'd0);
        aluValid = 1'b1; aluAddr = 5'd0; aluData = 32'h1111;
        readAddress1 = 5'd0;
        tick();
        aluValid = 1'b0;
        check("fwd.r0_valid", {63'd0, fwdValid1}, 64'd0);
        check("fwd.r0_data", {32'd0, fwdData1}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
